// File: rtl/hazard_scoreboard_if.sv
// Pipeline-to-scoreboard bundle: IF/ID operand info, load writeback and redirect in,
// stall/flush control and scoreboard state out.
interface hazard_scoreboard_if #(
    parameter int REG_AW   = 5,
    parameter int MAX_PEND = 4,
    parameter int SCNT_W   = 16
);
    localparam int NREGS = 2**REG_AW;
    localparam int PCW   = $clog2(MAX_PEND + 1);

    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              id_valid;
    logic              id_is_load;
    logic [REG_AW-1:0] id_rd;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic              redirect;
    logic              stall_pc;
    logic              stall_if_id;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic [NREGS-1:0]  busy_vec;
    logic [PCW-1:0]    pend_cnt;
    logic [SCNT_W-1:0] stall_cycles;
    logic              underflow_err;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_valid, id_is_load, id_rd,
               wb_valid, wb_rd, redirect,
        input  stall_pc, stall_if_id, flush_if_id, flush_id_ex,
               busy_vec, pend_cnt, stall_cycles, underflow_err
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_valid, id_is_load, id_rd,
               wb_valid, wb_rd, redirect,
        output stall_pc, stall_if_id, flush_if_id, flush_id_ex,
               busy_vec, pend_cnt, stall_cycles, underflow_err
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Load-use / outstanding-load scoreboard: tracks registers awaiting load data and
// produces stall/flush control for a simple in-order pipeline.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int MAX_PEND = 4,
    parameter int SCNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_scoreboard_if.slave  sb
);
    localparam int NREGS = 2**REG_AW;
    localparam int PCW   = $clog2(MAX_PEND + 1);
    localparam logic [REG_AW-1:0] REG0      = {REG_AW{1'b0}};
    localparam logic [PCW-1:0]    PEND_FULL = PCW'(MAX_PEND);
    localparam logic [PCW-1:0]    PEND_ZERO = {PCW{1'b0}};
    localparam logic [PCW-1:0]    PEND_ONE  = PCW'(1'b1);
    localparam logic [SCNT_W-1:0] SCNT_MAX  = {SCNT_W{1'b1}};
    localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1'b1);

    logic [NREGS-1:0]  busy_r;
    logic [NREGS-1:0]  busy_nxt_s;
    logic [PCW-1:0]    pend_r;
    logic [PCW-1:0]    pend_nxt_s;
    logic [SCNT_W-1:0] stall_r;
    logic              uf_r;
    logic              uf_set_s;
    logic              raw1_s;
    logic              raw2_s;
    logic              struct_s;
    logic              hz_s;
    logic              issue_s;
    logic              ld_issue_s;
    logic              stall_pc_s;
    logic              stall_if_id_s;
    logic              flush_if_id_s;
    logic              flush_id_ex_s;

    // Hazard detection; a writeback landing this cycle bypasses the RAW check.
    always_comb begin
        raw1_s     = sb.id_use_rs1 && (sb.id_rs1 != REG0) && busy_r[sb.id_rs1]
                     && !(sb.wb_valid && (sb.wb_rd == sb.id_rs1));
        raw2_s     = sb.id_use_rs2 && (sb.id_rs2 != REG0) && busy_r[sb.id_rs2]
                     && !(sb.wb_valid && (sb.wb_rd == sb.id_rs2));
        struct_s   = sb.id_valid && sb.id_is_load && (pend_r == PEND_FULL) && !sb.wb_valid;
        hz_s       = sb.id_valid && (raw1_s || raw2_s || struct_s) && !sb.redirect;
        issue_s    = sb.id_valid && !hz_s && !sb.redirect;
        ld_issue_s = issue_s && sb.id_is_load;
    end

    // Pipeline control; redirect takes priority over any hazard.
    always_comb begin
        stall_pc_s    = 1'b0;
        stall_if_id_s = 1'b0;
        flush_if_id_s = 1'b0;
        flush_id_ex_s = 1'b0;
        if (sb.redirect) begin
            flush_if_id_s = 1'b1;
            flush_id_ex_s = 1'b1;
        end else if (hz_s) begin
            stall_pc_s    = 1'b1;
            stall_if_id_s = 1'b1;
            flush_id_ex_s = 1'b1;
        end else begin
            stall_pc_s    = 1'b0;
        end
    end

    // Busy-bit next state: a load issue setting an index beats a writeback clearing it.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 0; i < NREGS; i++) begin
            busy_nxt_s[i] = (ld_issue_s && (sb.id_rd != REG0) && (sb.id_rd == REG_AW'(i)))
                         || (busy_r[i] && !(sb.wb_valid && (sb.wb_rd != REG0)
                                            && (sb.wb_rd == REG_AW'(i))));
        end
    end

    // Outstanding-load count; a writeback with nothing outstanding flags underflow.
    always_comb begin
        pend_nxt_s = pend_r;
        uf_set_s   = 1'b0;
        case ({ld_issue_s, sb.wb_valid})
            2'b10: pend_nxt_s = pend_r + PEND_ONE;
            2'b01: begin
                if (pend_r == PEND_ZERO) begin
                    uf_set_s = 1'b1;
                end else begin
                    pend_nxt_s = pend_r - PEND_ONE;
                end
            end
            default: pend_nxt_s = pend_r;
        endcase
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r  <= {NREGS{1'b0}};
            pend_r  <= PEND_ZERO;
            stall_r <= {SCNT_W{1'b0}};
            uf_r    <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            pend_r <= pend_nxt_s;
            uf_r   <= uf_r | uf_set_s;
            if (hz_s && (stall_r != SCNT_MAX)) begin
                stall_r <= stall_r + SCNT_ONE;
            end else begin
                stall_r <= stall_r;
            end
        end
    end

    assign sb.stall_pc      = stall_pc_s;
    assign sb.stall_if_id   = stall_if_id_s;
    assign sb.flush_if_id   = flush_if_id_s;
    assign sb.flush_id_ex   = flush_id_ex_s;
    assign sb.busy_vec      = busy_r;
    assign sb.pend_cnt      = pend_r;
    assign sb.stall_cycles  = stall_r;
    assign sb.underflow_err = uf_r;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default instance plus a SCNT_W=2 instance
// sharing the same stimulus for the saturation case.
module tb_hazard_scoreboard;
    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, id_valid, id_is_load, wb_valid, redirect;
    int         n_checks;
    int         n_errors;

    hazard_scoreboard_if #(.REG_AW(5), .MAX_PEND(4), .SCNT_W(16)) sb ();
    hazard_scoreboard_if #(.REG_AW(5), .MAX_PEND(4), .SCNT_W(2))  sb2 ();

    hazard_scoreboard #(.REG_AW(5), .MAX_PEND(4), .SCNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .sb(sb));
    hazard_scoreboard #(.REG_AW(5), .MAX_PEND(4), .SCNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .sb(sb2));

    assign sb.id_rs1 = id_rs1;          assign sb2.id_rs1 = id_rs1;
    assign sb.id_rs2 = id_rs2;          assign sb2.id_rs2 = id_rs2;
    assign sb.id_use_rs1 = id_use_rs1;  assign sb2.id_use_rs1 = id_use_rs1;
    assign sb.id_use_rs2 = id_use_rs2;  assign sb2.id_use_rs2 = id_use_rs2;
    assign sb.id_valid = id_valid;      assign sb2.id_valid = id_valid;
    assign sb.id_is_load = id_is_load;  assign sb2.id_is_load = id_is_load;
    assign sb.id_rd = id_rd;            assign sb2.id_rd = id_rd;
    assign sb.wb_valid = wb_valid;      assign sb2.wb_valid = wb_valid;
    assign sb.wb_rd = wb_rd;            assign sb2.wb_rd = wb_rd;
    assign sb.redirect = redirect;      assign sb2.redirect = redirect;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; wb_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_valid = 1'b0; id_is_load = 1'b0;
        wb_valid = 1'b0; redirect = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] rd);
        idle();
        id_valid = 1'b1; id_is_load = 1'b1; id_rd = rd;
    endtask

    task automatic ctrl(input string tag, input logic [3:0] exp);
        #1;
        chk(tag, {28'd0, sb.stall_pc, sb.stall_if_id, sb.flush_if_id, sb.flush_id_ex},
            {28'd0, exp});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        rst_n = 1'b0;
        // Reset state, with redirect showing control still live during reset
        redirect = 1'b1;
        #12;
        chk("rst_busy", sb.busy_vec, 32'd0);
        chk("rst_pend", {29'd0, sb.pend_cnt}, 32'd0);
        chk("rst_stall", {16'd0, sb.stall_cycles}, 32'd0);
        chk("rst_uf", {31'd0, sb.underflow_err}, 32'd0);
        ctrl("rst_redirect_ctrl", 4'b0011);
        idle();
        tick();
        rst_n = 1'b1;
        tick();

        // Load x5, consumer stalls exactly one cycle, issues on wb cycle
        load(5'd5);
        ctrl("lu_load_ctrl", 4'b0000);
        tick();
        chk("lu_busy5", sb.busy_vec, 32'h0000_0020);
        chk("lu_pend1", {29'd0, sb.pend_cnt}, 32'd1);
        idle();
        id_valid = 1'b1; id_use_rs1 = 1'b1; id_rs1 = 5'd5;
        ctrl("lu_stall_ctrl", 4'b1101);
        tick();
        chk("lu_stall_cnt", {16'd0, sb.stall_cycles}, 32'd1);
        wb_valid = 1'b1; wb_rd = 5'd5;
        ctrl("lu_bypass_ctrl", 4'b0000);
        tick();
        chk("lu_busy_clr", sb.busy_vec, 32'd0);
        chk("lu_pend0", {29'd0, sb.pend_cnt}, 32'd0);
        chk("lu_stall_cnt2", {16'd0, sb.stall_cycles}, 32'd1);

        // Load to x0 never marks busy, consumer of x0 never stalls
        load(5'd0);
        tick();
        chk("x0_pend1", {29'd0, sb.pend_cnt}, 32'd1);
        chk("x0_busy", sb.busy_vec, 32'd0);
        idle();
        id_valid = 1'b1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd0;
        ctrl("x0_ctrl", 4'b0000);
        tick();
        chk("x0_pend0", {29'd0, sb.pend_cnt}, 32'd0);

        // Four loads fill the tracker, fifth waits for a writeback
        for (int i = 1; i <= 4; i++) begin
            load(5'(i));
            tick();
        end
        chk("st_pend4", {29'd0, sb.pend_cnt}, 32'd4);
        chk("st_busy", sb.busy_vec, 32'h0000_001E);
        load(5'd6);
        ctrl("st_hold1", 4'b1101);
        tick();
        ctrl("st_hold2", 4'b1101);
        tick();
        chk("st_stall_cnt", {16'd0, sb.stall_cycles}, 32'd3);
        chk("st_stall_cnt_sat2", {30'd0, sb2.stall_cycles}, 32'd3);
        wb_valid = 1'b1; wb_rd = 5'd1;
        ctrl("st_release", 4'b0000);
        tick();
        chk("st_pend_keep4", {29'd0, sb.pend_cnt}, 32'd4);
        chk("st_busy2", sb.busy_vec, 32'h0000_005C);
        idle();
        wb_valid = 1'b1; wb_rd = 5'd2; tick();
        wb_rd = 5'd3; tick();
        wb_rd = 5'd4; tick();
        wb_rd = 5'd6; tick();
        chk("drain_pend", {29'd0, sb.pend_cnt}, 32'd0);
        chk("drain_busy", sb.busy_vec, 32'd0);
        chk("drain_uf", {31'd0, sb.underflow_err}, 32'd0);

        // Redirect overrides a raw hazard and leaves the scoreboard intact
        load(5'd7);
        tick();
        idle();
        id_valid = 1'b1; id_use_rs2 = 1'b1; id_rs2 = 5'd7; redirect = 1'b1;
        ctrl("rd_ctrl", 4'b0011);
        tick();
        chk("rd_busy7", sb.busy_vec, 32'h0000_0080);
        chk("rd_pend1", {29'd0, sb.pend_cnt}, 32'd1);
        chk("rd_stall_cnt", {16'd0, sb.stall_cycles}, 32'd3);
        idle();
        wb_valid = 1'b1; wb_rd = 5'd7;
        tick();
        chk("rd_busy_clr", sb.busy_vec, 32'd0);

        // Underflow is sticky until reset
        idle();
        wb_valid = 1'b1; wb_rd = 5'd9;
        tick();
        chk("uf_set", {31'd0, sb.underflow_err}, 32'd1);
        chk("uf_pend0", {29'd0, sb.pend_cnt}, 32'd0);
        load(5'd3);
        tick();
        chk("uf_persist", {31'd0, sb.underflow_err}, 32'd1);
        chk("uf_busy3", sb.busy_vec, 32'h0000_0008);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", sb.busy_vec, 32'd0);
        chk("arst_pend", {29'd0, sb.pend_cnt}, 32'd0);
        chk("arst_uf", {31'd0, sb.underflow_err}, 32'd0);
        chk("arst_stall", {16'd0, sb.stall_cycles}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Continuous hazard: 16-bit counts up, 2-bit saturates
        load(5'd9);
        tick();
        idle();
        id_valid = 1'b1; id_use_rs1 = 1'b1; id_rs1 = 5'd9;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk($sformatf("sat_w16_%0d", c), {16'd0, sb.stall_cycles}, 32'(c));
            chk($sformatf("sat_w2_%0d", c), {30'd0, sb2.stall_cycles}, (c < 3) ? 32'(c) : 32'd3);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
